// File: rtl/seq_det_pkg.sv
// Shared definitions for the generic serial pattern detector.
package seq_det_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_MOORE_OVL  = 2'b00;
  localparam mode_t MODE_MOORE_NOVL = 2'b01;
  localparam mode_t MODE_MEALY_OVL  = 2'b10;
  localparam mode_t MODE_MEALY_NOVL = 2'b11;

  // Widest pattern the masked compare supports.
  localparam int unsigned CMP_W = 32;

  // Mode bit 1 selects combinational (Mealy) output.
  function automatic logic is_mealy(input mode_t m);
    return m[1];
  endfunction

  // Mode bit 0 selects non-overlapping detection.
  function automatic logic is_nonovl(input mode_t m);
    return m[0];
  endfunction

  // Compare the low len bits of pat and hist.
  function automatic logic masked_eq(input logic [CMP_W-1:0] pat,
                                     input logic [CMP_W-1:0] hist,
                                     input int unsigned len);
    logic eq;
    eq = 1'b1;
    for (int unsigned i = 0; i < CMP_W; i++) begin
      if ((i < len) && (pat[i] != hist[i])) eq = 1'b0;
    end
    return eq;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, hold at all-ones.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_gen.sv
// Runtime-programmable serial bit-pattern detector with match counter.
module seq_detector_gen
  import seq_det_pkg::*;
#(
  parameter int unsigned     PAT_W    = 8,
  parameter int unsigned     CNT_W    = 8,
  parameter logic [PAT_W-1:0] RST_PAT = 8'b0000_0101,
  parameter int unsigned     RST_LEN  = 3,
  parameter logic [1:0]      RST_MODE = 2'b00
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       data_in,
  input  logic                       data_valid,
  input  logic                       cfg_load,
  input  logic [PAT_W-1:0]           pattern,
  input  logic [$clog2(PAT_W+1)-1:0] pat_len,
  input  logic [1:0]                 mode,
  output logic                       detected,
  output logic [CNT_W-1:0]           match_count,
  output logic                       cfg_len_err
);

  localparam int unsigned LEN_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0] hist;
  logic [LEN_W-1:0] fill;
  logic [PAT_W-1:0] cfg_pat;
  logic [LEN_W-1:0] cfg_len;
  mode_t            cfg_mode;
  logic             moore_q;

  logic [PAT_W-1:0] shifted;
  logic             fill_ok;
  logic             match_now;

  // History as it would look with the presented bit accepted, plus match decision.
  always_comb begin
    shifted   = {hist[PAT_W-2:0], data_in};
    fill_ok   = ((LEN_W+1)'(fill) + (LEN_W+1)'(1)) >= (LEN_W+1)'(cfg_len);
    match_now = data_valid && !cfg_load && (cfg_len != '0) && fill_ok &&
                masked_eq(CMP_W'(cfg_pat), CMP_W'(shifted), CMP_W'(cfg_len));
  end

  assign detected = is_mealy(cfg_mode) ? match_now : moore_q;

  // Configuration latch, history shift, fill tracking and Moore register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hist        <= '0;
      fill        <= '0;
      moore_q     <= 1'b0;
      cfg_pat     <= RST_PAT;
      cfg_len     <= LEN_W'(RST_LEN);
      cfg_mode    <= RST_MODE;
      cfg_len_err <= 1'b0;
    end else if (cfg_load) begin
      hist        <= '0;
      fill        <= '0;
      moore_q     <= 1'b0;
      cfg_pat     <= pattern;
      cfg_mode    <= mode;
      if (pat_len > LEN_W'(PAT_W)) begin
        cfg_len     <= LEN_W'(PAT_W);
        cfg_len_err <= 1'b1;
      end else begin
        cfg_len     <= pat_len;
        cfg_len_err <= 1'b0;
      end
    end else begin
      moore_q <= match_now;
      if (data_valid) begin
        hist <= shifted;
        if (match_now && is_nonovl(cfg_mode)) begin
          fill <= '0;
        end else if (fill != LEN_W'(PAT_W)) begin
          fill <= fill + LEN_W'(1);
        end
      end
    end
  end

  // Saturating count of every match.
  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (match_now),
    .count (match_count)
  );

endmodule
